fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx_pkg.sv | 23 ++
 rtl/fifo_serial_tx_bit_timer.sv | 50 +++++
 rtl/fifo_serial_tx.sv | 171 +++++++++++++++++
 tb/tb_fifo_serial_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// Shared constants for the FIFO-fed serial transmitter: data width,
// the default bit period, the 3-bit state encodings and the parity helper.
package fifo_serial_tx_pkg;

    localparam int DATA_W           = 10;
    localparam int CLKS_PER_BIT_DEF = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    localparam logic [3:0] LAST_BIT_IDX = 4'd9;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises a registered tick
// during the last cycle of every period. While restart is high the count is
// held at zero, so the first period after restart drops is a full period.
// tick_next announces that tick will be high in the following cycle, which
// lets the parent register its end-of-frame pulse without a decode glitch.
module bit_timer
    import fifo_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick,
    output logic tick_next
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       tick_r;

    // Next count: hold at zero on restart, wrap at the end of a period.
    always_comb begin
        cnt_next_s = 8'd0;
        if (restart) begin
            cnt_next_s = 8'd0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
    end

    // Count register and registered end-of-period tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r  <= 8'd0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == LAST_CNT);
        end
    end

    assign tick      = tick_r;
    assign tick_next = (cnt_next_s == LAST_CNT);

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO-fed serial transmitter. Pops one word from an upstream FIFO, then
// sends start bit, 10 data bits LSB first, optional even parity and a stop
// bit. All outputs are registered from the next-state values so each one
// lines up exactly with the state it belongs to.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Empty,
    input  logic [DATA_W-1:0] Din,
    output logic              RD_EN,
    output logic              TX,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        Word_Cnt
);

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;
    logic [3:0]        bit_idx_r;
    logic [3:0]        bit_idx_next_s;
    logic              parity_r;
    logic              parity_next_s;
    logic              tx_r;
    logic              tx_next_s;
    logic              rd_en_r;
    logic              busy_r;
    logic              done_r;
    logic              done_next_s;
    logic [7:0]        word_cnt_r;
    logic              restart_s;
    logic              tick_s;
    logic              tick_next_s;

    // The bit timer free-runs only while a frame is on the line.
    assign restart_s = (state_r == ST_IDLE) || (state_r == ST_READ) || (state_r == ST_LOAD);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK       (CLK),
        .RST       (RST),
        .restart   (restart_s),
        .tick      (tick_s),
        .tick_next (tick_next_s)
    );

    // Next state, shift register, bit index and parity.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        parity_next_s  = parity_r;
        case (state_r)
            ST_IDLE: begin
                if (!Empty) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_next_s = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next_s   = Din;
                parity_next_s  = even_parity(Din);
                bit_idx_next_s = 4'd0;
                state_next_s   = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_idx_r == LAST_BIT_IDX) begin
                        bit_idx_next_s = 4'd0;
                        if (PARITY_EN) begin
                            state_next_s = ST_PARITY;
                        end else begin
                            state_next_s = ST_STOP;
                        end
                    end else begin
                        bit_idx_next_s = bit_idx_r + 4'd1;
                        shift_next_s   = {1'b0, shift_r[DATA_W-1:1]};
                        state_next_s   = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from the coming state.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = parity_next_s;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Done marks the last STOP cycle: next state is STOP and the timer ends its period.
    assign done_next_s = (state_next_s == ST_STOP) && tick_next_s;

    // State, datapath and registered outputs; reset abandons any partial frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_W{1'b0}};
            bit_idx_r  <= 4'd0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            rd_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            word_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_idx_r <= bit_idx_next_s;
            parity_r  <= parity_next_s;
            tx_r      <= tx_next_s;
            rd_en_r   <= (state_next_s == ST_READ);
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= done_next_s;
            if (done_next_s) begin
                word_cnt_r <= word_cnt_r + 8'd1;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    assign RD_EN    = rd_en_r;
    assign TX       = tx_r;
    assign Busy     = busy_r;
    assign Done     = done_r;
    assign Word_Cnt = word_cnt_r;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: two instances (no parity / even parity), each fed
// by a small FIFO model. Words pushed by the stimulus also go into an
// expected queue; a monitor decodes every frame from TX and compares it.
module tb_fifo_serial_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty0, empty1;
    logic [9:0] din0, din1;
    logic       rd_en0, tx0, busy0, done0;
    logic       rd_en1, tx1, busy1, done1;
    logic [7:0] wc0, wc1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [9:0]  fifo0[$];
    logic [9:0]  fifo1[$];
    logic [10:0] exp0[$];
    logic [10:0] exp1[$];

    int rd_cnt0 = 0, rd_cnt1 = 0, last_rd0 = 0, last_rd1 = 0, rd_gap0 = 0, rd_gap1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0;

    assign empty0 = (fifo0.size() == 0);
    assign empty1 = (fifo1.size() == 0);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .Empty(empty0), .Din(din0), .RD_EN(rd_en0),
        .TX(tx0), .Busy(busy0), .Done(done0), .Word_Cnt(wc0)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .Empty(empty1), .Din(din1), .RD_EN(rd_en1),
        .TX(tx1), .Busy(busy1), .Done(done1), .Word_Cnt(wc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // FIFO model 0: pop on RD_EN, present the word in the following cycle only.
    initial begin : fifo_model0
        logic [9:0] w;
        din0 = 10'h3FF;
        forever begin
            @(negedge clk);
            if (rd_en0 === 1'b1) begin
                check("rd_en0_with_data", (fifo0.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (fifo0.size() > 0) w = fifo0.pop_front(); else w = 10'h3FF;
                rd_gap0  = cyc - last_rd0;
                last_rd0 = cyc;
                rd_cnt0++;
                @(posedge clk); #1 din0 = w;
                @(posedge clk); #1 din0 = ~w;
            end
        end
    end

    // FIFO model 1: same behaviour for the parity instance.
    initial begin : fifo_model1
        logic [9:0] w;
        din1 = 10'h3FF;
        forever begin
            @(negedge clk);
            if (rd_en1 === 1'b1) begin
                check("rd_en1_with_data", (fifo1.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (fifo1.size() > 0) w = fifo1.pop_front(); else w = 10'h3FF;
                rd_gap1  = cyc - last_rd1;
                last_rd1 = cyc;
                rd_cnt1++;
                @(posedge clk); #1 din1 = w;
                @(posedge clk); #1 din1 = ~w;
            end
        end
    end

    int   ph[2], cnt[2], bi[2], flen[2];
    logic lvl[2], par[2], unstable[2], bad_done[2], done_seen[2];
    logic [9:0] acc[2];

    // One monitor step per negedge: decode the frame and compare against the scoreboard.
    task automatic mon_step(input int id, input logic tx, input logic done, input int pen);
        logic [10:0] e;
        int          qsz;
        if (rst === 1'b1) begin
            ph[id] = 0;
        end else if (ph[id] == 0) begin
            if (tx === 1'b0) begin
                ph[id] = 1; cnt[id] = 1; flen[id] = 1; lvl[id] = 1'b0;
                unstable[id] = 1'b0; bad_done[id] = done; done_seen[id] = 1'b0;
            end else if (done === 1'b1) begin
                check("done_outside_frame", 32'(done), 32'd0);
            end
        end else begin
            flen[id]++;
            if (cnt[id] == 0) lvl[id] = tx;
            else if (tx !== lvl[id]) unstable[id] = 1'b1;
            if (ph[id] == 4 && cnt[id] == CPB - 1) done_seen[id] = done;
            else if (done === 1'b1) bad_done[id] = 1'b1;
            if (cnt[id] == CPB - 1) begin
                cnt[id] = 0;
                case (ph[id])
                    1: begin check("start_bit", 32'(lvl[id]), 32'd0); ph[id] = 2; bi[id] = 0; end
                    2: begin
                        acc[id][bi[id]] = lvl[id];
                        if (bi[id] == 9) ph[id] = (pen != 0) ? 3 : 4;
                        else bi[id]++;
                    end
                    3: begin par[id] = lvl[id]; ph[id] = 4; end
                    default: begin
                        check("stop_bit", 32'(lvl[id]), 32'd1);
                        check("bits_stable", 32'(unstable[id]), 32'd0);
                        check("done_last_stop", 32'(done_seen[id]), 32'd1);
                        check("done_single_pulse", 32'(bad_done[id]), 32'd0);
                        check("frame_len", 32'(flen[id]), 32'((12 + pen) * CPB));
                        qsz = (id == 0) ? exp0.size() : exp1.size();
                        check("frame_expected", (qsz > 0) ? 32'd1 : 32'd0, 32'd1);
                        if (qsz > 0) begin
                            if (id == 0) e = exp0.pop_front(); else e = exp1.pop_front();
                            check("data_word", 32'(acc[id]), 32'(e[9:0]));
                            if (pen != 0) check("parity_bit", 32'(par[id]), 32'(e[10]));
                        end
                        ph[id] = 0;
                    end
                endcase
            end else begin
                cnt[id]++;
            end
        end
    endtask

    // Monitor process: decoupled from stimulus, runs every negedge.
    initial begin : monitor
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; cnt[k] = 0; bi[k] = 0; flen[k] = 0;
        end
        forever begin
            @(negedge clk);
            mon_step(0, tx0, done0, 0);
            mon_step(1, tx1, done1, 1);
            if (done0 === 1'b1) done_cnt0++;
            if (done1 === 1'b1) done_cnt1++;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [9:0] w, input logic p);
        if (id == 0) begin fifo0.push_back(w); exp0.push_back({p, w}); end
        else begin fifo1.push_back(w); exp1.push_back({p, w}); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_n(2);
        check("rst_tx0", 32'(tx0), 32'd1);       check("rst_tx1", 32'(tx1), 32'd1);
        check("rst_rd_en0", 32'(rd_en0), 32'd0); check("rst_rd_en1", 32'(rd_en1), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);   check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);   check("rst_done1", 32'(done1), 32'd0);
        check("rst_wc0", 32'(wc0), 32'd0);       check("rst_wc1", 32'(wc1), 32'd0);
        rst = 1'b0;
        rd_cnt0 = 0; rd_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    endtask

    task automatic wait_drain(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick_n(1);
            if (fifo0.size() == 0 && fifo1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
                busy0 === 1'b0 && busy1 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_within_budget", 32'(ok), 32'd1);
    endtask

    initial begin : stimulus
        logic found;
        logic bad;

        // Reset state.
        do_reset();

        // Single word 32: bits 0000010000 LSB first, 48-cycle frame.
        push(0, 10'd32, 1'b0);
        wait_drain(200);
        check("single_rd_pulses", 32'(rd_cnt0), 32'd1);
        check("single_done_pulses", 32'(done_cnt0), 32'd1);
        check("single_word_cnt", 32'(wc0), 32'd1);

        // Back-to-back 29 then 53: RD_EN pulses 48+3 cycles apart.
        do_reset();
        push(0, 10'd29, 1'b0);
        push(0, 10'd53, 1'b0);
        wait_drain(300);
        check("b2b_rd_pulses", 32'(rd_cnt0), 32'd2);
        check("b2b_rd_gap", 32'(rd_gap0), 32'd51);
        check("b2b_word_cnt", 32'(wc0), 32'd2);

        // Parity instance: 7 has three ones -> parity 1, 3 has two -> parity 0; 52-cycle frames.
        push(1, 10'd7, 1'b1);
        push(1, 10'd3, 1'b0);
        wait_drain(300);
        check("par_rd_gap", 32'(rd_gap1), 32'd55);
        check("par_word_cnt", 32'(wc1), 32'd2);

        // Reset in the middle of data bit 4 of a frame.
        do_reset();
        push(0, 10'h155, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en0 === 1'b1) begin found = 1'b1; break; end
        end
        check("midrst_rd_seen", 32'(found), 32'd1);
        repeat (23) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", 32'(tx0), 32'd1);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        rst = 1'b0;
        exp0.delete();
        tick_n(60);
        check("midrst_no_done", 32'(done_cnt0), 32'd0);
        check("midrst_word_cnt", 32'(wc0), 32'd0);
        push(0, 10'd1, 1'b0);
        wait_drain(200);
        check("after_rst_word_cnt", 32'(wc0), 32'd1);

        // Empty held high: no reads, line idle.
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick_n(1);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) bad = 1'b1;
        end
        check("idle_tx_high", 32'(bad), 32'd0);
        check("idle_no_rd0", 32'(rd_cnt0), 32'd0);
        check("idle_no_rd1", 32'(rd_cnt1), 32'd0);

        // 256 frames: Word_Cnt reaches 255 then wraps to 0.
        for (int i = 0; i < 255; i++) push(0, 10'(i * 37), 1'b0);
        wait_drain(255 * 51 + 200);
        check("wrap_255", 32'(wc0), 32'd255);
        push(0, 10'h2C3, 1'b0);
        wait_drain(200);
        check("wrap_0", 32'(wc0), 32'd0);
        check("wrap_done_pulses", 32'(done_cnt0), 32'd256);
        check("wrap_rd_pulses", 32'(rd_cnt0), 32'd256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
